image_receiver: RTL

- UART-side receiver for the image link. Deserialises the 8N1 byte stream the FPGA image sender produces and reassembles 12-bit pixels.
- Writes each pixel into a frame buffer, with sequential addresses and a write strobe.
- Sits between the uart_in pin (after the board pin) and a dual-port frame RAM. Used for loopback test and for the Nano-to-FPGA return path.

---
 rtl/image_link_pkg.sv | 17 +
 rtl/uart_byte_rx.sv | 93 +++++++++
 rtl/image_receiver.sv | 99 +++++++++
 3 files changed

// File: rtl/image_link_pkg.sv
// Shared widths, byte-protocol constants and the UART byte FSM state type
// for the image link receive path.
package image_link_pkg;

    localparam int PIXEL_W         = 12;
    localparam int ADDR_W          = 17;
    localparam logic [3:0] BYTE0_PAD = 4'b0000;
    localparam int BYTES_PER_PIXEL = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchroniser on the line, then a start/data/stop FSM
// sampling at bit centres. byte_valid and stop_error are single-cycle pulses.
module uart_byte_rx
    import image_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_error,
    output logic       rx_active,
    output rx_state_t  rx_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync_ff1;
    logic             rx_s;
    logic             rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff1   <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            stop_error <= 1'b0;
        end else begin
            sync_ff1   <= uart_in;
            rx_s       <= sync_ff1;
            rx_prev    <= rx_s;
            byte_valid <= 1'b0;
            stop_error <= 1'b0;
            case (rx_state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (rx_prev && !rx_s) rx_state <= START;
                end
                START: begin
                    // A line that is high again at mid start bit was only a glitch.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= IDLE;
                        if (rx_s) begin
                            byte_data  <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            stop_error <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    assign rx_active = (rx_state != IDLE);

endmodule

// File: rtl/image_receiver.sv
// Reassembles 12-bit pixels from byte pairs on the UART link and writes them
// to the frame buffer at sequential addresses, wrapping after a full frame.
module image_receiver
    import image_link_pkg::*;
#(
    parameter int CLK_FREQ          = 50_000_000,
    parameter int BAUD_RATE         = 9600,
    parameter int CLKS_PER_BIT      = CLK_FREQ / BAUD_RATE,
    parameter int NUM_PIXELS        = 320 * 240,
    parameter int BYTE_TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_in,
    output logic [ADDR_W-1:0]  wr_address,
    output logic [PIXEL_W-1:0] wr_pixel,
    output logic               wr_en,
    output logic               frame_done,
    output logic               framing_error,
    output logic               busy
);

    localparam int TO_W = $clog2(BYTE_TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(BYTE_TIMEOUT_CLKS - 1);
    localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(NUM_PIXELS);

    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              stop_error;
    logic              rx_active;
    rx_state_t         rx_state;

    logic              phase;
    logic [3:0]        hi_nibble;
    logic [TO_W-1:0]   timeout_cnt;
    logic [ADDR_W-1:0] pixel_cnt;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .stop_error (stop_error),
        .rx_active  (rx_active),
        .rx_state   (rx_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase         <= 1'b0;
            hi_nibble     <= '0;
            timeout_cnt   <= '0;
            pixel_cnt     <= '0;
            wr_address    <= '0;
            wr_pixel      <= '0;
            wr_en         <= 1'b0;
            frame_done    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            wr_en         <= 1'b0;
            framing_error <= 1'b0;

            if (wr_en) begin
                pixel_cnt <= wr_address + 1'b1;
                if (({1'b0, wr_address} + 1'b1) == FRAME_END) frame_done <= 1'b1;
            end

            if (!phase || rx_active) timeout_cnt <= '0;
            else                     timeout_cnt <= timeout_cnt + 1'b1;

            if (stop_error) begin
                framing_error <= 1'b1;
                phase         <= 1'b0;
            end else if (byte_valid) begin
                if (!phase) begin
                    if (byte_data[7:4] == BYTE0_PAD) begin
                        phase     <= 1'b1;
                        hi_nibble <= byte_data[3:0];
                    end else begin
                        framing_error <= 1'b1;
                    end
                end else begin
                    // frame_done marks a held count of NUM_PIXELS: restart at 0.
                    phase      <= 1'b0;
                    wr_pixel   <= {hi_nibble, byte_data};
                    wr_address <= frame_done ? '0 : pixel_cnt;
                    frame_done <= 1'b0;
                    wr_en      <= 1'b1;
                end
            end else if (phase && timeout_cnt == TO_LAST) begin
                phase <= 1'b0;
            end
        end
    end

    assign busy = (rx_state != IDLE) || phase;

endmodule
